// File: rtl/regfile_bypass.sv
// 32-entry register file with two combinational read ports and EX/MEM/WB
// forwarding so dependent back-to-back ops read the youngest in-flight value.

module regfile_bypass_rd #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata
);
    // Youngest source wins: EX, then MEM, then the retiring WB write, then the array.
    always_comb begin
        rdata = '0;
        if (!rst || !re || raddr == '0)
            rdata = '0;
        else if (BYPASS_EN && ex_wreg && ex_wd == raddr)
            rdata = ex_wdata;
        else if (BYPASS_EN && mem_wreg && mem_wd == raddr)
            rdata = mem_wdata;
        else if (we && waddr == raddr)
            rdata = wdata;
        else
            rdata = arr_data;
    end
endmodule

module regfile_bypass #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NREG      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              ex_wreg_i,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i
);
    localparam int NUM_PORTS = 2;

    logic [NREG-1:0][DATA_W-1:0]      regs;
    logic [NUM_PORTS-1:0]             re;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] raddr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

    assign re     = {re2, re1};
    assign raddr  = {raddr2, raddr1};
    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs <= '0;
        else if (we && waddr != '0)
            regs[waddr] <= wdata;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        regfile_bypass_rd #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS_EN(BYPASS_EN)
        ) u_rd (
            .rst      (rst),
            .re       (re[p]),
            .raddr    (raddr[p]),
            .arr_data (regs[raddr[p]]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .ex_wreg  (ex_wreg_i),
            .ex_wd    (ex_wd_i),
            .ex_wdata (ex_wdata_i),
            .mem_wreg (mem_wreg_i),
            .mem_wd   (mem_wd_i),
            .mem_wdata(mem_wdata_i),
            .rdata    (rdata[p])
        );
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed table plus reset and random sequences for regfile_bypass, with
// forwarding on (u_byp) and off (u_nob) driven from the same inputs.

module tb_regfile_bypass;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, re1, re2, ex_wreg, mem_wreg;
    logic [4:0]  waddr, raddr1, raddr2, ex_wd, mem_wd;
    logic [31:0] wdata, ex_wdata, mem_wdata;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_bypass #(.BYPASS_EN(1'b1)) u_byp (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(b_rd1),
        .re2(re2), .raddr2(raddr2), .rdata2(b_rd2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata));

    regfile_bypass #(.BYPASS_EN(1'b0)) u_nob (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(n_rd1),
        .re2(re2), .raddr2(raddr2), .rdata2(n_rd2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata));

    typedef struct {
        logic        we;  logic [4:0] wa;  logic [31:0] wd;
        logic        re1; logic [4:0] ra1;
        logic        re2; logic [4:0] ra2;
        logic        exw; logic [4:0] exd; logic [31:0] exv;
        logic        mw;  logic [4:0] md;  logic [31:0] mv;
        logic [31:0] e1, e2, n1, n2;
    } vec_t;

    vec_t vt[14];
    logic [31:0] ref_regs[32];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
    endtask

    task automatic apply(input vec_t v);
        we = v.we; waddr = v.wa; wdata = v.wd;
        re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
        ex_wreg = v.exw; ex_wd = v.exd; ex_wdata = v.exv;
        mem_wreg = v.mw; mem_wd = v.md; mem_wdata = v.mv;
    endtask

    function automatic logic [31:0] model(input bit byp, input logic re,
                                          input logic [4:0] ra);
        if (!re || ra == 0) return 32'h0;
        if (byp && ex_wreg && ex_wd == ra) return ex_wdata;
        if (byp && mem_wreg && mem_wd == ra) return mem_wdata;
        if (we && waddr == ra) return wdata;
        return ref_regs[ra];
    endfunction

    initial begin
        // Each row is checked before the edge; the row's write lands on that edge.
        vt[0]  = '{1,0,32'hFFFFFFFF, 1,0, 1,0, 0,0,0, 0,0,0, 0,0,0,0};
        vt[1]  = '{0,0,0, 1,0, 1,5, 0,0,0, 0,0,0, 0,0,0,0};
        vt[2]  = '{1,3,32'hA5A5A5A5, 1,3, 1,3, 0,0,0, 0,0,0,
                   32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5};
        vt[3]  = '{0,0,0, 1,3, 1,3, 0,0,0, 0,0,0,
                   32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5};
        vt[4]  = '{1,7,32'h11, 1,7, 1,3, 0,0,0, 0,0,0,
                   32'h11,32'hA5A5A5A5,32'h11,32'hA5A5A5A5};
        vt[5]  = '{1,7,32'h22, 1,7, 1,7, 1,7,32'h44, 1,7,32'h33,
                   32'h44,32'h44,32'h22,32'h22};
        vt[6]  = '{1,7,32'h22, 1,7, 1,7, 0,7,32'h44, 1,7,32'h33,
                   32'h33,32'h33,32'h22,32'h22};
        vt[7]  = '{1,7,32'h22, 1,7, 1,7, 0,7,32'h44, 0,7,32'h33,
                   32'h22,32'h22,32'h22,32'h22};
        vt[8]  = '{0,0,0, 1,7, 1,7, 0,0,0, 0,0,0, 32'h22,32'h22,32'h22,32'h22};
        vt[9]  = '{1,9,32'h66, 1,9, 0,0, 0,0,0, 0,0,0, 32'h66,0,32'h66,0};
        vt[10] = '{0,0,0, 1,9, 0,9, 1,9,32'h55, 0,0,0, 32'h55,0,32'h66,0};
        vt[11] = '{1,0,32'h99, 1,0, 1,0, 1,0,32'h77, 1,0,32'h88, 0,0,0,0};
        vt[12] = '{0,0,0, 1,3, 1,9, 0,3,32'hDEAD, 1,3,32'hBEEF,
                   32'hBEEF,32'h66,32'hA5A5A5A5,32'h66};
        vt[13] = '{0,0,0, 1,3, 1,9, 1,9,32'h1, 0,3,32'hBEEF,
                   32'hA5A5A5A5,32'h1,32'hA5A5A5A5,32'h66};

        idle();
        rst = 0;
        re1 = 1; raddr1 = 3; ex_wreg = 1; ex_wd = 3; ex_wdata = 32'h1;
        #1;
        chk("rst_gate_byp", 0, b_rd1, 32'h0);
        chk("rst_gate_nob", 0, n_rd1, 32'h0);
        #11 rst = 1;
        idle();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vt[i]);
            #1;
            chk("byp_rd1", i, b_rd1, vt[i].e1);
            chk("byp_rd2", i, b_rd2, vt[i].e2);
            chk("nob_rd1", i, n_rd1, vt[i].n1);
            chk("nob_rd2", i, n_rd2, vt[i].n2);
        end

        // Reset wipes the array and ignores a write attempted while it is held.
        @(negedge clk);
        idle(); we = 1; waddr = 5; wdata = 32'h1234;
        @(negedge clk);
        idle(); re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 7;
        #1;
        chk("pre_rst_r5", 0, b_rd1, 32'h1234);
        we = 1; waddr = 5; wdata = 32'hFFFF;
        rst = 0;
        #1;
        chk("in_rst_rd1", 0, b_rd1, 32'h0);
        chk("in_rst_rd2", 0, b_rd2, 32'h0);
        @(negedge clk);
        rst = 1; we = 0;
        #1;
        chk("post_rst_r5", 0, b_rd1, 32'h0);
        chk("post_rst_r7", 0, b_rd2, 32'h0);
        raddr1 = 3; raddr2 = 9;
        #1;
        chk("post_rst_r3", 0, b_rd1, 32'h0);
        chk("post_rst_r9", 0, n_rd2, 32'h0);

        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            we = 1'($urandom); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
            re1 = ($urandom_range(0, 7) != 0); raddr1 = 5'($urandom_range(0, 7));
            re2 = ($urandom_range(0, 7) != 0); raddr2 = 5'($urandom_range(0, 7));
            ex_wreg = 1'($urandom); ex_wd = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
            mem_wreg = 1'($urandom); mem_wd = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
            #1;
            chk("rnd_byp1", c, b_rd1, model(1, re1, raddr1));
            chk("rnd_byp2", c, b_rd2, model(1, re2, raddr2));
            chk("rnd_nob1", c, n_rd1, model(0, re1, raddr1));
            chk("rnd_nob2", c, n_rd2, model(0, re2, raddr2));
            @(posedge clk);
            if (we && waddr != 0) ref_regs[waddr] = wdata;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
